// File: rtl/mem_access_pkg.sv
// Shared opcodes, FSM states, common constants and opcode classification helpers for the memory-access stage.
package mem_access_pkg;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LH  = 4'd2,
    MEM_LW  = 4'd3,
    MEM_LBU = 4'd4,
    MEM_LHU = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_WAIT,
    MEM_DONE
  } mem_state_e;

  localparam logic        RST_ENABLE    = 1'b1;
  localparam logic [31:0] ZERO_WORD     = '0;
  localparam logic [4:0]  ZERO_REG      = '0;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
           (op == MEM_LBU) || (op == MEM_LHU);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  function automatic logic op_is_byte(input logic [3:0] op);
    return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_SB);
  endfunction

  function automatic logic op_is_half(input logic [3:0] op);
    return (op == MEM_LH) || (op == MEM_LHU) || (op == MEM_SH);
  endfunction

  function automatic logic op_is_word(input logic [3:0] op);
    return (op == MEM_LW) || (op == MEM_SW);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: byte enables, store replication, load extract/extend.
// MEM_MISALIGN_TRAP_EN: flag misaligned half/word accesses instead of silently aligning them.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_sdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_sel,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata,
  output logic        o_misalign
);

  logic [1:0]  w_a;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_a = i_addr_lo;
    if (op_is_half(i_op)) w_a[0] = 1'b0;
    if (op_is_word(i_op)) w_a    = 2'b00;
  end

  assign w_byte = i_rdata[{w_a, 3'b000} +: 8];
  assign w_half = i_rdata[{w_a[1], 4'b0000} +: 16];

  always_comb begin
    o_sel   = '0;
    o_wdata = ZERO_WORD;
    if (op_is_byte(i_op)) begin
      o_sel   = 4'b0001 << w_a;
      o_wdata = {4{i_sdata[7:0]}};
    end else if (op_is_half(i_op)) begin
      o_sel   = 4'b0011 << {w_a[1], 1'b0};
      o_wdata = {2{i_sdata[15:0]}};
    end else if (op_is_word(i_op)) begin
      o_sel   = 4'b1111;
      o_wdata = i_sdata;
    end
  end

  always_comb begin
    o_ldata = ZERO_WORD;
    case (i_op)
      MEM_LB:  o_ldata = {{24{w_byte[7]}}, w_byte};
      MEM_LBU: o_ldata = {24'd0, w_byte};
      MEM_LH:  o_ldata = {{16{w_half[15]}}, w_half};
      MEM_LHU: o_ldata = {16'd0, w_half};
      MEM_LW:  o_ldata = i_rdata;
      default: o_ldata = ZERO_WORD;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign o_misalign = (op_is_half(i_op) && i_addr_lo[0]) ||
                      (op_is_word(i_op) && (i_addr_lo != 2'b00));
`else
  assign o_misalign = 1'b0;
`endif

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: ALU passthrough plus req/ack data-bus FSM with timeout and load buffer.
// MEM_MISALIGN_TRAP_EN (see mem_lane_align) turns misaligned half/word accesses into misalign_o.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic        reg_we_i,
  input  logic [31:0] reg_wdata_i,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_sdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic [4:0]  reg_waddr_o,
  output logic        reg_we_o,
  output logic [31:0] reg_wdata_o,
  output logic        stallreq_o,
  output logic        bus_err_o,
  output logic        misalign_o
);

  localparam int unsigned  CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  mem_state_e    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic [31:0]   r_lbuf;
  logic          r_req;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [3:0]    r_sel;
  logic [31:0]   r_wdata;

  logic [3:0]    w_sel;
  logic [31:0]   w_wdata;
  logic [31:0]   w_ldata;
  logic          w_misalign;
  logic          w_is_load;
  logic          w_is_mem;

  assign w_is_load = op_is_load(mem_op_i);
  assign w_is_mem  = w_is_load || op_is_store(mem_op_i);

  // Load extraction works on the buffered word; op and address are held by the stall.
  mem_lane_align u_lane (
    .i_op       (mem_op_i),
    .i_addr_lo  (mem_addr_i[1:0]),
    .i_sdata    (mem_sdata_i),
    .i_rdata    (r_lbuf),
    .o_sel      (w_sel),
    .o_wdata    (w_wdata),
    .o_ldata    (w_ldata),
    .o_misalign (w_misalign)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i == RST_ENABLE) begin
      r_state <= MEM_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_lbuf  <= ZERO_WORD;
      r_req   <= 1'b0;
      r_we    <= WRITE_DISABLE;
      r_addr  <= ZERO_WORD;
      r_sel   <= '0;
      r_wdata <= ZERO_WORD;
    end else begin
      case (r_state)
        MEM_IDLE: begin
          if (w_is_mem && !w_misalign) begin
            r_req   <= 1'b1;
            r_we    <= op_is_store(mem_op_i);
            r_addr  <= {mem_addr_i[31:2], 2'b00};
            r_sel   <= w_sel;
            r_wdata <= w_wdata;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_state <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          // Ack is tested first so an ack on the last allowed cycle is not an error.
          if (mem_ack_i) begin
            r_lbuf  <= mem_rdata_i;
            r_req   <= 1'b0;
            r_we    <= WRITE_DISABLE;
            r_sel   <= '0;
            r_state <= MEM_DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_req   <= 1'b0;
            r_we    <= WRITE_DISABLE;
            r_sel   <= '0;
            r_err   <= 1'b1;
            r_state <= MEM_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        MEM_DONE: begin
          r_cnt   <= '0;
          r_err   <= 1'b0;
          r_state <= MEM_IDLE;
        end
        default: r_state <= MEM_IDLE;
      endcase
    end
  end

  assign mem_req_o   = r_req;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_sel_o   = r_sel;
  assign mem_wdata_o = r_wdata;

  always_comb begin
    reg_waddr_o = reg_waddr_i;
    reg_we_o    = reg_we_i;
    reg_wdata_o = reg_wdata_i;
    stallreq_o  = 1'b0;
    bus_err_o   = 1'b0;
    misalign_o  = 1'b0;
    if (rst_i == RST_ENABLE) begin
      reg_waddr_o = ZERO_REG;
      reg_we_o    = WRITE_DISABLE;
      reg_wdata_o = ZERO_WORD;
    end else begin
      case (r_state)
        MEM_IDLE: begin
          if (w_misalign) begin
            misalign_o = 1'b1;
            reg_we_o   = WRITE_DISABLE;
          end else if (w_is_mem) begin
            stallreq_o = 1'b1;
            reg_we_o   = WRITE_DISABLE;
          end
        end
        MEM_WAIT: begin
          stallreq_o = 1'b1;
          reg_we_o   = WRITE_DISABLE;
        end
        MEM_DONE: begin
          bus_err_o = r_err;
          if (w_is_load && !r_err) reg_wdata_o = w_ldata;
          else                     reg_we_o    = WRITE_DISABLE;
        end
        default: reg_we_o = WRITE_DISABLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus randomized loads/stores against a reference model.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  reg_waddr_i;
  logic        reg_we_i;
  logic [31:0] reg_wdata_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_sdata_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic [4:0]  reg_waddr_o;
  logic        reg_we_o;
  logic [31:0] reg_wdata_o;
  logic        stallreq_o;
  logic        bus_err_o;
  logic        misalign_o;

  int n_assert = 0;
  int n_fail   = 0;

  mem_access #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .reg_waddr_i (reg_waddr_i),
    .reg_we_i    (reg_we_i),
    .reg_wdata_i (reg_wdata_i),
    .mem_op_i    (mem_op_i),
    .mem_addr_i  (mem_addr_i),
    .mem_sdata_i (mem_sdata_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_sel_o   (mem_sel_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i),
    .reg_waddr_o (reg_waddr_o),
    .reg_we_o    (reg_we_o),
    .reg_wdata_o (reg_wdata_o),
    .stallreq_o  (stallreq_o),
    .bus_err_o   (bus_err_o),
    .misalign_o  (misalign_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #300000;
    $display("FAIL watchdog: observed no end of test, expected finish before 300000ns");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes, natural alignment, lane arithmetic.
  function automatic logic [31:0] m_size(input logic [3:0] op);
    if (op == MEM_LB || op == MEM_LBU || op == MEM_SB) return 32'd1;
    if (op == MEM_LH || op == MEM_LHU || op == MEM_SH) return 32'd2;
    return 32'd4;
  endfunction

  function automatic logic m_is_load(input logic [3:0] op);
    return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
  endfunction

  function automatic logic [31:0] m_offset(input logic [3:0] op, input logic [31:0] addr);
    logic [31:0] off;
    off = addr % 32'd4;
    return off - (off % m_size(op));
  endfunction

  function automatic logic [31:0] m_sel(input logic [3:0] op, input logic [31:0] addr);
    return ((32'd1 << m_size(op)) - 32'd1) << m_offset(op, addr);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] sdata);
    if (m_size(op) == 32'd1) return (sdata % 32'd256) * 32'h0101_0101;
    if (m_size(op) == 32'd2) return (sdata % 32'd65536) * 32'h0001_0001;
    return sdata;
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    logic [31:0] v;
    v = rdata >> (32'd8 * m_offset(op, addr));
    if (m_size(op) == 32'd1) begin
      v = v % 32'd256;
      if (op == MEM_LB && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (m_size(op) == 32'd2) begin
      v = v % 32'd65536;
      if (op == MEM_LH && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  // Entered and left at posedge+1 with the DUT idle; ack_at=0 means the bus never answers.
  task automatic run_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] rdata, input int unsigned ack_at,
                         input logic [4:0] waddr, input logic we, input logic [31:0] alu);
    int unsigned k;
    int unsigned stalls;
    logic        err;
    mem_op_i    = op;
    mem_addr_i  = addr;
    mem_sdata_i = sdata;
    reg_waddr_i = waddr;
    reg_we_i    = we;
    reg_wdata_i = alu;
    mem_ack_i   = 1'b0;
    #1;
`ifdef MEM_MISALIGN_TRAP_EN
    if ((addr % m_size(op)) != 32'd0) begin
      check("trap_misalign", 32'(misalign_o), 32'd1);
      check("trap_stall", 32'(stallreq_o), 32'd0);
      check("trap_we", 32'(reg_we_o), 32'd0);
      @(posedge clk_i); #1;
      check("trap_noreq", 32'(mem_req_o), 32'd0);
      mem_op_i = MEM_NOP;
      return;
    end
    check("trap_aligned", 32'(misalign_o), 32'd0);
`else
    check("misalign_tied", 32'(misalign_o), 32'd0);
`endif
    err    = (ack_at == 0);
    k      = err ? 16 : ack_at;
    stalls = 32'(stallreq_o);
    check("idle_we", 32'(reg_we_o), 32'd0);
    check("idle_req", 32'(mem_req_o), 32'd0);
    for (int unsigned c = 1; c <= k; c++) begin
      @(posedge clk_i); #1;
      stalls += 32'(stallreq_o);
      check("wait_req", 32'(mem_req_o), 32'd1);
      check("wait_we", 32'(reg_we_o), 32'd0);
      if (c == 1) begin
        check("bus_addr", mem_addr_o, addr - (addr % 32'd4));
        check("bus_sel", 32'(mem_sel_o), m_sel(op, addr));
        check("bus_we", 32'(mem_we_o), m_is_load(op) ? 32'd0 : 32'd1);
        if (!m_is_load(op)) check("bus_wdata", mem_wdata_o, m_wdata(op, sdata));
      end
      if (c == ack_at) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = rdata;
      end
    end
    @(posedge clk_i); #1;
    mem_ack_i   = 1'b0;
    mem_rdata_i = $urandom;
    check("stall_cycles", stalls, 32'(k + 1));
    check("done_stall", 32'(stallreq_o), 32'd0);
    check("done_req", 32'(mem_req_o), 32'd0);
    check("done_err", 32'(bus_err_o), 32'(err));
    check("done_waddr", 32'(reg_waddr_o), 32'(waddr));
    if (m_is_load(op) && !err) begin
      check("done_we", 32'(reg_we_o), 32'(we));
      check("done_ldata", reg_wdata_o, m_load(op, addr, rdata));
    end else begin
      check("done_we", 32'(reg_we_o), 32'd0);
    end
    @(posedge clk_i); #1;
    mem_op_i = MEM_NOP;
    #1;
    check("post_err", 32'(bus_err_o), 32'd0);
    check("post_pass", reg_wdata_o, alu);
  endtask

  logic [3:0] ops [8];

  initial begin
    ops = '{MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW};
    rst_i       = 1'b1;
    reg_waddr_i = 5'd9;
    reg_we_i    = 1'b1;
    reg_wdata_i = 32'hDEAD_BEEF;
    mem_op_i    = MEM_LW;
    mem_addr_i  = 32'h0000_0400;
    mem_sdata_i = 32'h1111_2222;
    mem_rdata_i = 32'h0;
    mem_ack_i   = 1'b1;
    #3;
    check("rst_req", 32'(mem_req_o), 32'd0);
    check("rst_stall", 32'(stallreq_o), 32'd0);
    check("rst_we", 32'(reg_we_o), 32'd0);
    check("rst_wdata", reg_wdata_o, 32'd0);
    check("rst_waddr", 32'(reg_waddr_o), 32'd0);
    check("rst_sel", 32'(mem_sel_o), 32'd0);
    mem_ack_i = 1'b0;
    mem_op_i  = MEM_NOP;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // NOP passthrough in the same cycle
    reg_wdata_i = 32'h0000_1234;
    reg_we_i    = 1'b1;
    reg_waddr_i = 5'd3;
    #1;
    check("nop_wdata", reg_wdata_o, 32'h0000_1234);
    check("nop_we", 32'(reg_we_o), 32'd1);
    check("nop_waddr", 32'(reg_waddr_o), 32'd3);
    check("nop_stall", 32'(stallreq_o), 32'd0);
    reg_we_i = 1'b0;
    #1;
    check("nop_we0", 32'(reg_we_o), 32'd0);

    run_mem(MEM_LB, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 3, 5'd4, 1'b1, 32'h0);
    run_mem(MEM_SH, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 2, 5'd5, 1'b1, 32'h77);
    run_mem(MEM_LW, 32'h0000_0300, 32'h0, 32'h1234_5678, 0, 5'd6, 1'b1, 32'h99);
    run_mem(MEM_LW, 32'h0000_0300, 32'h0, 32'h1234_5678, 16, 5'd6, 1'b1, 32'h98);
    run_mem(MEM_LW, 32'h0000_0101, 32'h0, 32'hCAFE_F00D, 1, 5'd7, 1'b1, 32'h1);

    // Reset while waiting for ack; the late ack must not revive the transaction
    mem_op_i    = MEM_LW;
    mem_addr_i  = 32'h0000_0500;
    reg_we_i    = 1'b1;
    reg_wdata_i = 32'h55;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    check("mid_req", 32'(mem_req_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check("mid_rst_req", 32'(mem_req_o), 32'd0);
    check("mid_rst_stall", 32'(stallreq_o), 32'd0);
    check("mid_rst_we", 32'(reg_we_o), 32'd0);
    check("mid_rst_wdata", reg_wdata_o, 32'd0);
    check("mid_rst_addr", mem_addr_o, 32'd0);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hFFFF_FFFF;
    mem_op_i    = MEM_NOP;
    @(posedge clk_i); #1;
    rst_i       = 1'b0;
    reg_wdata_i = 32'hCAFE_0001;
    reg_waddr_i = 5'd7;
    @(posedge clk_i); #1;
    check("late_ack_req", 32'(mem_req_o), 32'd0);
    check("late_ack_stall", 32'(stallreq_o), 32'd0);
    check("late_ack_err", 32'(bus_err_o), 32'd0);
    check("late_ack_pass", reg_wdata_o, 32'hCAFE_0001);
    check("late_ack_we", 32'(reg_we_o), 32'd1);
    mem_ack_i = 1'b0;

    for (int i = 0; i < 40; i++) begin
      int unsigned r;
      int unsigned ack_at;
      r      = $urandom_range(0, 9);
      ack_at = (r == 0) ? 0 : (r == 1) ? 16 : r - 1;
      run_mem(ops[$urandom_range(0, 7)], $urandom, $urandom, $urandom, ack_at,
              5'($urandom), 1'($urandom), $urandom);
      reg_wdata_i = $urandom;
      reg_we_i    = 1'($urandom);
      #1;
      check("rand_nop_pass", reg_wdata_o, reg_wdata_i);
      check("rand_nop_we", 32'(reg_we_o), 32'(reg_we_i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
